// File: rtl/alp_seq_if.sv
// ---------------------------------------------------------------------------
// alp_seq_if
// Bus between an operand source / result sink and alp_seq_unit.
// Optional feature macro: ALP_ABORT_EN (adds the ABORT request line).
//
// Signals (master = requester, slave = alp_seq_unit):
//   START    request, sampled by the unit only in IDLE or DONE
//   OP[2:0]  000 ADD 001 SUB 010 MUL 011 DIV 100 AND 101 OR 110 XOR 111 PASSB
//   A, B     W-bit two's complement operands
//   ABORT    (ALP_ABORT_EN only) cancel a MUL/DIV in progress
//   RES_LO   result low / quotient
//   RES_HI   product high / remainder / zero
//   BUSY     operation in progress
//   DONE     one-cycle completion strobe
//   NFLAG, ZFLAG, OVF, ERR  result status
// ---------------------------------------------------------------------------
interface alp_seq_if #(
    parameter int W = 8
);
    logic         START;
    logic [2:0]   OP;
    logic [W-1:0] A;
    logic [W-1:0] B;
`ifdef ALP_ABORT_EN
    logic         ABORT;
`endif
    logic [W-1:0] RES_LO;
    logic [W-1:0] RES_HI;
    logic         BUSY;
    logic         DONE;
    logic         NFLAG;
    logic         ZFLAG;
    logic         OVF;
    logic         ERR;

    modport master (
`ifdef ALP_ABORT_EN
        output ABORT,
`endif
        output START, OP, A, B,
        input  RES_LO, RES_HI, BUSY, DONE, NFLAG, ZFLAG, OVF, ERR
    );

    modport slave (
`ifdef ALP_ABORT_EN
        input  ABORT,
`endif
        input  START, OP, A, B,
        output RES_LO, RES_HI, BUSY, DONE, NFLAG, ZFLAG, OVF, ERR
    );
endinterface

// File: rtl/alp_seq_unit.sv
// ---------------------------------------------------------------------------
// alp_seq_unit
// Multi-cycle W-bit arithmetic/logic unit: single-cycle ADD/SUB/logic,
// radix-2 Booth signed multiply (W iterations) and signed restoring divide
// (W iterations on magnitudes plus one sign fix-up cycle).
// Optional feature macro: ALP_ABORT_EN (ABORT cancels MUL/DIV/FIX).
//
// Ports:
//   CLK   rising-edge clock
//   CLR   asynchronous active-high reset (state IDLE, all outputs 0)
//   bus   alp_seq_if slave modport: START/OP/A/B in, results and flags out
// ---------------------------------------------------------------------------
module alp_seq_unit #(
    parameter int W = 8
) (
    input  logic       CLK,
    input  logic       CLR,
    alp_seq_if.slave   bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX, S_DONE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic signed [W-1:0] a_q;
    logic signed [W-1:0] b_q;
    // MUL: Booth accumulator; DIV: partial remainder (top bit unused there)
    logic signed [W:0]   acc_q;
    // MUL: multiplier shifting out; DIV: dividend magnitude -> quotient
    logic [W-1:0]        q_q;
    logic                qm1_q;

    logic [W-1:0]        res_lo_q;
    logic [W-1:0]        res_hi_q;
    logic                busy_q;
    logic                done_q;
    logic                n_q;
    logic                z_q;
    logic                ovf_q;
    logic                err_q;

    function automatic logic [W-1:0] f_neg(input logic [W-1:0] x);
        return ~x + 1'b1;
    endfunction

    // Magnitude as unsigned, so -2^(W-1) maps to 2^(W-1) without loss
    function automatic logic [W-1:0] f_abs(input logic [W-1:0] x);
        return x[W-1] ? f_neg(x) : x;
    endfunction

    // Signed overflow of x + y given the wrapped sum s
    function automatic logic f_add_ovf(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic [W-1:0] s);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    logic signed [W:0]   m_ext;
    logic signed [W:0]   booth_sum;
    logic signed [W:0]   booth_acc_d;
    logic [W-1:0]        booth_q_d;
    logic [W-1:0]        dvs_mag;
    logic [W:0]          div_shift;
    logic [W:0]          div_rem_d;
    logic [W-1:0]        div_q_d;
    logic [W-1:0]        exec_lo_d;
    logic                exec_ovf_d;
    logic [W-1:0]        quot_d;
    logic [W-1:0]        rem_d;
    logic                div_ovf_d;
    logic                last_iter;

    always_comb begin
        // Booth step: add/subtract multiplicand, then arithmetic shift of
        // {ACC,Q,Q-1}; ACC is one bit wider so -2^(W-1) survives negation.
        m_ext     = {a_q[W-1], a_q};
        booth_sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        booth_acc_d = booth_sum >>> 1;
        booth_q_d   = {booth_sum[0], q_q[W-1:1]};

        // Restoring step: shift next dividend bit into the remainder and
        // subtract the divisor only if it fits.
        dvs_mag   = f_abs(b_q);
        div_shift = {acc_q[W-1:0], q_q[W-1]};
        if (div_shift >= {1'b0, dvs_mag}) begin
            div_rem_d = div_shift - {1'b0, dvs_mag};
            div_q_d   = {q_q[W-2:0], 1'b1};
        end else begin
            div_rem_d = div_shift;
            div_q_d   = {q_q[W-2:0], 1'b0};
        end

        // Single-cycle ops; the fall-through value doubles as the
        // divide-by-zero quotient.
        exec_ovf_d = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_lo_d  = a_q + b_q;
                exec_ovf_d = f_add_ovf(a_q, b_q, exec_lo_d);
            end
            OP_SUB: begin
                exec_lo_d  = a_q - b_q;
                exec_ovf_d = f_add_ovf(a_q, ~b_q, exec_lo_d);
            end
            OP_AND:  exec_lo_d = a_q & b_q;
            OP_OR:   exec_lo_d = a_q | b_q;
            OP_XOR:  exec_lo_d = a_q ^ b_q;
            OP_MUL,
            OP_DIV:  exec_lo_d = '1;
            default: exec_lo_d = b_q;
        endcase

        // Sign fix-up: quotient truncates toward zero, remainder follows A
        quot_d    = (a_q[W-1] ^ b_q[W-1]) ? f_neg(q_q) : q_q;
        rem_d     = a_q[W-1] ? f_neg(acc_q[W-1:0]) : acc_q[W-1:0];
        div_ovf_d = (a_q == MIN_V) && (b_q == {W{1'b1}});
        last_iter = (cnt_q == CW'(W - 1));
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (bus.START) begin
                        op_q   <= bus.OP;
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        qm1_q  <= 1'b0;
                        ovf_q  <= 1'b0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        case (bus.OP)
                            OP_MUL: begin
                                state_q <= S_MUL;
                                q_q     <= bus.B;
                            end
                            OP_DIV: begin
                                if (bus.B != '0) begin
                                    state_q <= S_DIV;
                                    q_q     <= f_abs(bus.A);
                                end else begin
                                    state_q <= S_EXEC;
                                end
                            end
                            default: state_q <= S_EXEC;
                        endcase
                    end
                end

                S_EXEC: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (op_q == OP_DIV) begin
                        // only a zero divisor reaches EXEC as DIV
                        res_lo_q <= '1;
                        res_hi_q <= a_q;
                        n_q      <= 1'b1;
                        z_q      <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        res_lo_q <= exec_lo_d;
                        res_hi_q <= '0;
                        n_q      <= exec_lo_d[W-1];
                        z_q      <= (exec_lo_d == '0);
                        ovf_q    <= exec_ovf_d;
                    end
                end

                S_MUL: begin
`ifdef ALP_ABORT_EN
                    if (bus.ABORT) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else
`endif
                    begin
                        acc_q <= booth_acc_d;
                        q_q   <= booth_q_d;
                        qm1_q <= q_q[0];
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            res_hi_q <= booth_acc_d[W-1:0];
                            res_lo_q <= booth_q_d;
                            n_q      <= booth_acc_d[W-1];
                            z_q      <= ({booth_acc_d[W-1:0], booth_q_d} == '0);
                        end
                    end
                end

                S_DIV: begin
`ifdef ALP_ABORT_EN
                    if (bus.ABORT) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else
`endif
                    begin
                        acc_q <= $signed(div_rem_d);
                        q_q   <= div_q_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            state_q <= S_FIX;
                        end
                    end
                end

                S_FIX: begin
`ifdef ALP_ABORT_EN
                    if (bus.ABORT) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else
`endif
                    begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (div_ovf_d) begin
                            res_lo_q <= MIN_V;
                            res_hi_q <= '0;
                            n_q      <= 1'b1;
                            z_q      <= 1'b0;
                            ovf_q    <= 1'b1;
                        end else begin
                            res_lo_q <= quot_d;
                            res_hi_q <= rem_d;
                            n_q      <= quot_d[W-1];
                            z_q      <= (quot_d == '0);
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RES_LO = res_lo_q;
    assign bus.RES_HI = res_hi_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.NFLAG  = n_q;
    assign bus.ZFLAG  = z_q;
    assign bus.OVF    = ovf_q;
    assign bus.ERR    = err_q;

endmodule
